// File: rtl/spi_reg_ctrl_if.sv
// Pad-level SPI pins between an SPI master and the spi_reg_ctrl slave.
interface spi_reg_ctrl_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (output sclk, output copi, output ncs, input cipo);
    modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI-slave write decoder feeding five 8-bit PWM configuration registers.
// Optional read-back of registers on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_ctrl #(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_reg_ctrl_if.slave spi,
    output logic [7:0]    en_reg_out_7_0,
    output logic [7:0]    en_reg_out_15_8,
    output logic [7:0]    en_reg_pwm_7_0,
    output logic [7:0]    en_reg_pwm_15_8,
    output logic [7:0]    pwm_duty_cycle,
    output logic          txn_done,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    // Storage is never narrower than the five mapped outputs.
    localparam int         STORE      = (NUM_REGS > 5) ? NUM_REGS : 5;
    localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_d, ncs_d;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic        fall_pend;
    logic        frame_ok;
    logic [7:0]  regs [STORE];

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
            sclk_d    <= sclk_s;
            ncs_d     <= ncs_s;
        end
    end

    assign frame_ok = (bit_cnt == 5'd16) && shift_reg[15] &&
                      ({1'b0, shift_reg[14:8]} < NUM_REGS_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            fall_pend <= 1'b0;
            txn_done  <= 1'b0;
            for (int i = 0; i < STORE; i++) regs[i] <= '0;
        end else begin
            txn_done <= 1'b0;
            case (state)
                // A frame already running when reset released must not be decoded.
                WAIT_IDLE: if (ncs_s) state <= IDLE;
                IDLE: begin
                    if (ncs_fall || fall_pend) begin
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        fall_pend <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise && !ncs_s) begin
                        shift_reg <= {shift_reg[14:0], copi_s};
                        if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (ncs_rise) state <= COMMIT;
                end
                COMMIT: begin
                    state <= IDLE;
                    if (ncs_fall) fall_pend <= 1'b1;
                    if (frame_ok) begin
                        txn_done <= 1'b1;
                        for (int i = 0; i < STORE; i++)
                            if (shift_reg[14:8] == 7'(i)) regs[i] <= shift_reg[7:0];
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];
    assign fsm_state       = state;

`ifdef SPI_READBACK_EN
    logic [7:0] rd_val;
    logic [7:0] rd_shift;
    logic       cipo_q;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < STORE; i++)
            if (shift_reg[6:0] == 7'(i)) rd_val = regs[i];
    end

    // After eight bits the header sits in shift_reg[7:0]; data goes out on bits 8..15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipo_q   <= 1'b0;
            rd_shift <= '0;
        end else if (state != SHIFT) begin
            cipo_q   <= 1'b0;
            rd_shift <= '0;
        end else if (sclk_fall) begin
            if (bit_cnt == 5'd8 && !shift_reg[7] &&
                ({1'b0, shift_reg[6:0]} < NUM_REGS_L)) begin
                cipo_q   <= rd_val[7];
                rd_shift <= {rd_val[6:0], 1'b0};
            end else if (bit_cnt > 5'd8 && bit_cnt < 5'd16) begin
                cipo_q   <= rd_shift[7];
                rd_shift <= {rd_shift[6:0], 1'b0};
            end else begin
                cipo_q   <= 1'b0;
                rd_shift <= '0;
            end
        end
    end

    assign spi.cipo = cipo_q;
`else
    assign spi.cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed plus randomized frames for spi_reg_ctrl against an address-indexed register model.
module tb_spi_reg_ctrl;
  localparam int PH   = 4;
  localparam int NREG = 5;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_reg_ctrl_if spi ();
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       txn_done;
  logic [1:0] fsm_state;

  spi_reg_ctrl #(.NUM_REGS(NREG), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi             (spi),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .txn_done        (txn_done),
    .fsm_state       (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int txn_cnt = 0;
  logic [7:0]  model [NREG];
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] reg_by_addr(input int a);
    case (a)
      0: return en_reg_out_7_0;
      1: return en_reg_out_15_8;
      2: return en_reg_pwm_7_0;
      3: return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  task automatic compare_regs(input string tag);
    for (int i = 0; i < NREG; i++) check($sformatf("%s_reg%0d", tag, i), reg_by_addr(i), model[i]);
  endtask

  // scoreboard: every txn_done pulse must match the oldest accepted write
  always @(negedge clk) begin
    if (txn_done === 1'b1) begin
      logic [15:0] e;
      txn_cnt++;
      if (exp_q.size() == 0) check("unexpected_txn", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("sb_commit", reg_by_addr(int'(e[14:8])), e[7:0]);
      end
    end
  end

  // Expected cipo bit stream, captured just before each sclk rise.
  function automatic logic [16:0] exp_cipo(input logic [16:0] val, input int n);
    logic [7:0]  hdr;
    logic [16:0] e;
    e = '0;
    hdr = 8'(val >> (n - 8));
    if (RB && n >= 9 && !hdr[7] && hdr[6:0] < NREG)
      for (int k = 8; k < n && k < 16; k++) e[n-1-k] = model[hdr[2:0]][15-k];
    return e;
  endfunction

  // driver tasks
  task automatic begin_frame();
    @(negedge clk);
    spi.ncs = 1'b0;
    repeat (PH) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [16:0] val, input int n, output logic [16:0] rd);
    rd = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi.copi = val[i];
      repeat (PH) @(negedge clk);
      rd = {rd[15:0], spi.cipo};
      spi.sclk = 1'b1;
      repeat (PH) @(negedge clk);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic finish_frame(input logic [16:0] val, input int n, input logic [16:0] rd,
                              input logic may_accept);
    logic acc;
    int   base;
    acc = may_accept && (n == 16) && val[15] && (val[14:8] < NREG);
    check("cipo_stream", rd, may_accept ? exp_cipo(val, n) : 17'h0);
    if (acc) exp_q.push_back(val[15:0]);
    repeat (PH) @(negedge clk);
    spi.ncs = 1'b1;
    base = txn_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("pre_commit_txn", txn_done, 0);
    compare_regs("pre");
    @(posedge clk);
    #1;
    check("commit_txn", txn_done, acc);
    if (acc) model[val[10:8]] = val[7:0];
    compare_regs("post");
    repeat (4) @(negedge clk);
    check("txn_count", txn_cnt - base, acc);
    check("cipo_idle", spi.cipo, 0);
  endtask

  task automatic do_frame(input logic [16:0] val, input int n);
    logic [16:0] rd;
    begin_frame();
    shift_bits(val, n, rd);
    finish_frame(val, n, rd, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] rd;
    logic [16:0] val;
    int          n, base, sel;
    logic [6:0]  addr;
    logic        rw;

    for (int i = 0; i < NREG; i++) model[i] = '0;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    repeat (3) @(negedge clk);
    compare_regs("reset");
    check("reset_txn", txn_done, 0);
    check("reset_cipo", spi.cipo, 0);
    check("reset_state", fsm_state, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // basic writes, reads and rejected frames
    do_frame(17'h080F0, 16);
    do_frame(17'h08455, 16);
    do_frame(17'h08201, 16);
    do_frame(17'h08512, 16);
    do_frame(17'h00421, 15);
    do_frame(17'h08033, 17);
    do_frame(17'h00400, 16);
    do_frame(17'h00700, 16);

    // reset in the middle of a frame, ncs held low through release
    begin_frame();
    shift_bits(17'h00083, 8, rd);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    compare_regs("async_clear");
    check("async_clear_state", fsm_state, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    shift_bits(17'h000AA, 8, rd);
    finish_frame(17'h083AA, 16, rd, 1'b0);
    do_frame(17'h083AA, 16);

    // back-to-back frames with ncs high for exactly three clocks
    base = txn_cnt;
    begin_frame();
    shift_bits(17'h08011, 16, rd);
    check("b2b_a_cipo", rd, exp_cipo(17'h08011, 16));
    exp_q.push_back(16'h8011);
    repeat (PH) @(negedge clk);
    spi.ncs = 1'b1;
    repeat (3) @(negedge clk);
    spi.ncs = 1'b0;
    model[0] = 8'h11;
    repeat (PH) @(negedge clk);
    shift_bits(17'h08122, 16, rd);
    finish_frame(17'h08122, 16, rd, 1'b1);
    check("b2b_total_txn", txn_cnt - base, 2);

    // randomized frames
    for (int t = 0; t < 30; t++) begin
      addr = 7'($urandom_range(0, 7));
      rw   = ($urandom_range(0, 3) != 0);
      sel  = $urandom_range(0, 5);
      if (sel == 0) begin
        n = 15;
        val = 17'($urandom) & 17'h07FFF;
      end else if (sel == 1) begin
        n = 17;
        val = 17'($urandom);
      end else begin
        n = 16;
        val = {1'b0, rw, addr, 8'($urandom)};
      end
      do_frame(val, n);
    end

    check("sb_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

SPI-slave register controller that configures the PWM output block of the onboarding design. It samples the pad-level SPI signals in the system clock domain and decodes fixed-format 16-bit write frames. Valid frames are committed into five configuration registers that drive output enable, PWM enable and PWM duty cycle. It sits between the `ui_in` pins and the PWM peripheral inside the top-level `tt_um_` wrapper.

## Interface
Parameters:
- `NUM_REGS`, default 5: number of implemented registers, at addresses 0x00..NUM_REGS-1.
- `SYNC_STAGES`, default 2: synchronizer depth for `sclk`, `copi` and `ncs`; minimum 2.

Ports:
- `clk`  input  1: system clock; all state is clocked on the rising edge.
- `rst_n`  input  1: reset, asynchronous assert, active-low.
- `sclk`  input  1: SPI clock (mode 0), asynchronous to `clk`.
- `copi`  input  1: SPI data in, MSB first.
- `ncs`  input  1: SPI chip select, active-low.
- `cipo`  output  1: SPI data out; constant 0 unless `SPI_READBACK_EN` is defined.
- `en_reg_out_7_0`  output  8: register 0x00.
- `en_reg_out_15_8`  output  8: register 0x01.
- `en_reg_pwm_7_0`  output  8: register 0x02.
- `en_reg_pwm_15_8`  output  8: register 0x03.
- `pwm_duty_cycle`  output  8: register 0x04.
- `txn_done`  output  1: one-cycle pulse when a valid write commits.

Reset: every output and all internal state go to 0 while `rst_n`=0; the FSM goes to WAIT_IDLE.

## Operation
- Frame format, 16 bits, MSB first:
  - bit15: R/W, where 1 = write.
  - bits14:8: address, 7 bits.
  - bits7:0: data.
- Synchronization and edge detection:
  - `sclk`, `copi` and `ncs` each pass through SYNC_STAGES flops.
  - A further flop on each of `sclk` and `ncs` provides edge detection.
  - `copi` is sampled on the synchronized `sclk` rising edge.
- FSM states:
  - WAIT_IDLE: ignore everything until synchronized `ncs`=1, then go to IDLE. This is the reset state, so a frame already in progress at reset release is never accepted.
  - IDLE: on `ncs` falling edge, clear the 5-bit bit counter and the shift register, then go to SHIFT.
  - SHIFT: each `sclk` rising edge shifts `copi` into the 16-bit shift register. The bit counter increments and saturates at 17. On `ncs` rising edge, go to COMMIT.
  - COMMIT: lasts one cycle, then returns to IDLE. The write happens only when count==16, R/W==1 and address < NUM_REGS. In that case the addressed register is loaded with data[7:0] and `txn_done` pulses in the same cycle.
- All other frames are discarded with no register change and no `txn_done`. This covers:
  - count ≠ 16, including count ≥ 17 (overlong frames);
  - R/W = 0 (read frames);
  - out-of-range addresses.
- `sclk` edges while `ncs`=1 are ignored.
- A `ncs` falling edge in COMMIT is not lost: its edge flag holds until IDLE consumes it on the next cycle.
- Registers hold their values indefinitely; only reset or a valid write changes them.

## Timing
- `clk` must run at ≥ 8× `sclk`. Each SCLK phase and the `ncs` high time between frames must last ≥ 3 `clk` periods.
- Commit latency: register outputs and `txn_done` update on the (SYNC_STAGES+2)th `clk` rising edge after `ncs` rises at the pin. With defaults, that is edge 4.
- Register outputs are glitch-free flop outputs and change only in the COMMIT cycle.
- Reset asserted mid-frame:
  - All registers clear immediately, asynchronously.
  - After release, the partial frame is dropped (WAIT_IDLE).
  - The next full frame after `ncs` returns high is accepted normally.

## Configuration
- `SPI_READBACK_EN` defined:
  - A frame with R/W=0 and a valid address returns the addressed register's value on `cipo` during bits 8..15, MSB first.
  - `cipo` is updated on each synchronized `sclk` falling edge. It is 0 during bits 0..7, between frames and for invalid addresses.
  - A read frame never modifies registers and never pulses `txn_done`.
- `SPI_READBACK_EN` undefined: `cipo` is tied to 0 and read frames are discarded.

## Test plan
- Reset, then write frame 0x80F0 → `en_reg_out_7_0`=0xF0, `txn_done` pulses once, all other registers stay 0x00.
- Write 0x8455, then 0x8201 → `pwm_duty_cycle`=0x55 and `en_reg_pwm_7_0`=0x01. Commit lands on the 4th `clk` edge after `ncs` rises.
- Invalid frames: write 0x8512 (address 5), a 15-bit frame 0x4 0x21, and a 17-bit frame → no register change and no `txn_done` for any of them.
- Reset pulse after 8 bits of 0x83AA, with `ncs` held low through reset release and the frame completed → 0x03 stays 0x00. A following 0x83AA frame → `en_reg_pwm_15_8`=0xAA.
- Back-to-back frames 0x8011 and 0x8122 with `ncs` high for exactly 3 `clk` → both commit.
- (`SPI_READBACK_EN`) Write 0x8455, then send read frame 0x0400 → `cipo` shifts 0x55 during bits 8..15 and `pwm_duty_cycle` is unchanged. Read 0x0700 → `cipo` stays 0.
